// File: rtl/fpu_mant_align_if.sv
// Handshake and operand/result bundle for the mantissa alignment stage.
// The master side drives operands and i_ready; the slave side (the aligner)
// drives o_ready and the aligned result.
interface fpu_mant_align_if #(
    parameter int SIZE_MAN = 24,
    parameter int SIZE_EXP = 8
);
    logic                  i_valid;
    logic                  o_ready;
    logic [SIZE_EXP-1:0]   i_exp_a;
    logic [SIZE_EXP-1:0]   i_exp_b;
    logic [SIZE_MAN-1:0]   i_man_a;
    logic [SIZE_MAN-1:0]   i_man_b;
    logic                  o_valid;
    logic                  i_ready;
    logic [SIZE_EXP-1:0]   o_exp_big;
    logic [SIZE_MAN-1:0]   o_man_big;
    logic [SIZE_MAN+1:0]   o_man_small;
    logic                  o_sticky;
    logic                  o_swap;

    modport master (
        output i_valid, i_exp_a, i_exp_b, i_man_a, i_man_b, i_ready,
        input  o_ready, o_valid, o_exp_big, o_man_big, o_man_small, o_sticky, o_swap
    );

    modport slave (
        input  i_valid, i_exp_a, i_exp_b, i_man_a, i_man_b, i_ready,
        output o_ready, o_valid, o_exp_big, o_man_big, o_man_small, o_sticky, o_swap
    );
endinterface

// File: rtl/fpu_mant_align.sv
// Two-stage mantissa alignment for a floating-point adder.
// Stage 1 orders the operands by magnitude and computes the exponent
// difference; stage 2 right-shifts the smaller mantissa (with guard and
// round bits appended) by that difference.
// Build option: define FPU_ALIGN_STICKY_EN to generate o_sticky (OR of all
// bits shifted past the round bit); otherwise o_sticky is tied to 0 and no
// sticky logic exists.
module fpu_mant_align #(
    parameter int SIZE_MAN = 24,
    parameter int SIZE_EXP = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    fpu_mant_align_if.slave bus
);
    localparam int SIZE_EXT = SIZE_MAN + 2;

    // Stage 1 registers: ordered operands and exponent difference
    logic                s1_valid_reg;
    logic                s1_swap_reg;
    logic [SIZE_EXP-1:0] s1_exp_big_reg;
    logic [SIZE_EXP-1:0] s1_d_reg;
    logic [SIZE_MAN-1:0] s1_man_big_reg;
    logic [SIZE_MAN-1:0] s1_man_small_reg;

    logic                s1_swap_next;
    logic [SIZE_EXP-1:0] s1_exp_big_next;
    logic [SIZE_EXP-1:0] s1_exp_small_next;
    logic [SIZE_EXP-1:0] s1_d_next;
    logic [SIZE_MAN-1:0] s1_man_big_next;
    logic [SIZE_MAN-1:0] s1_man_small_next;

    // Stage 2 registers: aligned result
    logic                s2_valid_reg;
    logic                s2_swap_reg;
    logic [SIZE_EXP-1:0] s2_exp_big_reg;
    logic [SIZE_MAN-1:0] s2_man_big_reg;
    logic [SIZE_EXT-1:0] s2_man_small_reg;
    logic [SIZE_EXT-1:0] s2_man_small_next;

    logic [SIZE_EXT-1:0] s1_man_ext;
    logic                s1_ready;
    logic                s2_ready;
    logic                in_fire;
    logic                s1_fire;

    // A stage can take new data when it is empty or its content leaves this cycle.
    assign s2_ready     = !s2_valid_reg || bus.i_ready;
    assign s1_ready     = !s1_valid_reg || s2_ready;
    assign in_fire      = bus.i_valid && s1_ready;
    assign s1_fire      = s1_valid_reg && s2_ready;
    assign bus.o_ready  = s1_ready;

    // Magnitude compare on {exp,man}; equal magnitudes keep A as the big operand.
    always_comb begin
        s1_swap_next      = ({bus.i_exp_a, bus.i_man_a} < {bus.i_exp_b, bus.i_man_b});
        s1_exp_big_next   = bus.i_exp_a;
        s1_exp_small_next = bus.i_exp_b;
        s1_man_big_next   = bus.i_man_a;
        s1_man_small_next = bus.i_man_b;
        if (s1_swap_next) begin
            s1_exp_big_next   = bus.i_exp_b;
            s1_exp_small_next = bus.i_exp_a;
            s1_man_big_next   = bus.i_man_b;
            s1_man_small_next = bus.i_man_a;
        end
        s1_d_next = s1_exp_big_next - s1_exp_small_next;
    end

    // Stage 1 register: valid follows the input whenever the stage can accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_reg     <= 1'b0;
            s1_swap_reg      <= 1'b0;
            s1_exp_big_reg   <= '0;
            s1_d_reg         <= '0;
            s1_man_big_reg   <= '0;
            s1_man_small_reg <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid_reg <= bus.i_valid;
            end
            if (in_fire) begin
                s1_swap_reg      <= s1_swap_next;
                s1_exp_big_reg   <= s1_exp_big_next;
                s1_d_reg         <= s1_d_next;
                s1_man_big_reg   <= s1_man_big_next;
                s1_man_small_reg <= s1_man_small_next;
            end
        end
    end

    // Guard and round positions start at 0; shifts of SIZE_EXT or more yield 0.
    assign s1_man_ext        = {s1_man_small_reg, 2'b00};
    assign s2_man_small_next = s1_man_ext >> s1_d_reg;

    // Stage 2 register: data only moves on a real transfer, so a stalled output holds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid_reg     <= 1'b0;
            s2_swap_reg      <= 1'b0;
            s2_exp_big_reg   <= '0;
            s2_man_big_reg   <= '0;
            s2_man_small_reg <= '0;
        end else begin
            if (s2_ready) begin
                s2_valid_reg <= s1_valid_reg;
            end
            if (s1_fire) begin
                s2_swap_reg      <= s1_swap_reg;
                s2_exp_big_reg   <= s1_exp_big_reg;
                s2_man_big_reg   <= s1_man_big_reg;
                s2_man_small_reg <= s2_man_small_next;
            end
        end
    end

`ifdef FPU_ALIGN_STICKY_EN
    logic [SIZE_EXT-1:0] s1_lost_bits;
    logic                s2_sticky_reg;

    // Bit gi of the extended mantissa is shifted out whenever the distance exceeds gi.
    for (genvar gi = 0; gi < SIZE_EXT; gi++) begin : g_lost
        assign s1_lost_bits[gi] = s1_man_ext[gi] && (32'(s1_d_reg) > 32'(gi));
    end

    // Sticky register advances together with the stage 2 data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_sticky_reg <= 1'b0;
        end else if (s1_fire) begin
            s2_sticky_reg <= |s1_lost_bits;
        end
    end

    assign bus.o_sticky = s2_sticky_reg;
`else
    assign bus.o_sticky = 1'b0;
`endif

    assign bus.o_valid     = s2_valid_reg;
    assign bus.o_swap      = s2_swap_reg;
    assign bus.o_exp_big   = s2_exp_big_reg;
    assign bus.o_man_big   = s2_man_big_reg;
    assign bus.o_man_small = s2_man_small_reg;
endmodule

// File: tb/tb_fpu_mant_align.sv
// Self-checking bench for fpu_mant_align: directed literal cases, a stalled
// 8-pair stream, a long random valid/ready run and a mid-flight reset, all
// scored against an arithmetic reference model and a queue scoreboard.
module tb_fpu_mant_align;
    localparam int SM = 24;
    localparam int SE = 8;
    localparam int SX = SM + 2;
`ifdef FPU_ALIGN_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    fpu_mant_align_if #(.SIZE_MAN(SM), .SIZE_EXP(SE)) bus ();

    fpu_mant_align #(.SIZE_MAN(SM), .SIZE_EXP(SE)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          swap;
        logic [SE-1:0] exp_big;
        logic [SM-1:0] man_big;
        logic [SX-1:0] man_small;
        logic          sticky;
    } res_t;

    res_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   pushed     = 0;
    int   popped     = 0;
    bit   prev_stall = 1'b0;
    res_t prev_out;

    // Reference: order by numeric magnitude, shift by exponent distance using plain arithmetic.
    function automatic res_t model(input logic [SE-1:0] ea, input logic [SM-1:0] ma,
                                   input logic [SE-1:0] eb, input logic [SM-1:0] mb);
        res_t r;
        longint unsigned mag_a, mag_b, ext;
        int d;
        logic [SM-1:0] m_small;
        mag_a = (longint'(ea) << SM) + longint'(ma);
        mag_b = (longint'(eb) << SM) + longint'(mb);
        r.swap = (mag_a < mag_b);
        if (r.swap) begin
            r.exp_big = eb; r.man_big = mb; m_small = ma; d = int'(eb) - int'(ea);
        end else begin
            r.exp_big = ea; r.man_big = ma; m_small = mb; d = int'(ea) - int'(eb);
        end
        ext = longint'(m_small) * 4;
        if (d >= SX) begin
            r.man_small = '0;
            r.sticky    = (m_small != 0);
        end else begin
            r.man_small = SX'(ext >> d);
            r.sticky    = ((ext % (64'd1 << d)) != 0);
        end
        if (!STICKY_ON) r.sticky = 1'b0;
        return r;
    endfunction

    function automatic res_t mk(input logic sw, input logic [SE-1:0] eb, input logic [SM-1:0] mb,
                                input logic [SX-1:0] ms, input logic st);
        res_t r;
        r.swap = sw; r.exp_big = eb; r.man_big = mb; r.man_small = ms; r.sticky = st;
        return r;
    endfunction

    function automatic res_t get_out();
        res_t r;
        r.swap = bus.o_swap; r.exp_big = bus.o_exp_big; r.man_big = bus.o_man_big;
        r.man_small = bus.o_man_small; r.sticky = bus.o_sticky;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_res(input string name, input res_t a, input res_t e);
        compared++;
        if (a.swap !== e.swap || a.exp_big !== e.exp_big || a.man_big !== e.man_big ||
            a.man_small !== e.man_small || a.sticky !== e.sticky) begin
            mismatched++;
            $display("FAIL %s: got swap=%0d exp_big=%02h man_big=%06h man_small=%07h sticky=%0d, required swap=%0d exp_big=%02h man_big=%06h man_small=%07h sticky=%0d",
                     name, a.swap, a.exp_big, a.man_big, a.man_small, a.sticky,
                     e.swap, e.exp_big, e.man_big, e.man_small, e.sticky);
        end
    endtask

    // Scoreboard and handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        res_t cur;
        res_t r;
        cur = get_out();
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("o_ready_vs_occupancy", bus.o_ready, !(exp_q.size() == 2 && !bus.i_ready));
            if (exp_q.size() != 1)
                check("o_valid_vs_occupancy", bus.o_valid, exp_q.size() == 2);
            if (prev_stall) begin
                check("stall_valid_hold", bus.o_valid, 1'b1);
                check_res("stall_data_hold", cur, prev_out);
            end
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    r = exp_q.pop_front();
                    popped++;
                    check_res("result", cur, r);
                    $display("out %0d: swap=%0d exp_big=%02h man_big=%06h man_small=%07h sticky=%0d",
                             popped, cur.swap, cur.exp_big, cur.man_big, cur.man_small, cur.sticky);
                end
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_out   = cur;
            if (bus.i_valid && bus.o_ready) begin
                exp_q.push_back(model(bus.i_exp_a, bus.i_man_a, bus.i_exp_b, bus.i_man_b));
                pushed++;
            end
        end
    end

    task automatic rand_ops();
        logic [SE-1:0] ea, eb, et;
        logic [SM-1:0] ma, mb, mt;
        int mode;
        ea   = SE'($urandom());
        ma   = SM'($urandom()) | (SM'(1) << (SM - 1));
        mb   = SM'($urandom()) | (SM'(1) << (SM - 1));
        mode = $urandom_range(0, 9);
        case (mode)
            0:       begin eb = ea; mb = ma; end
            1:       eb = ea;
            2, 3:    eb = ea - SE'($urandom_range(0, 30));
            4, 5:    eb = ea + SE'($urandom_range(0, 30));
            default: eb = SE'($urandom());
        endcase
        if ($urandom_range(0, 7) == 0) ma = SM'($urandom());
        if ($urandom_range(0, 1) == 1) begin
            et = ea; ea = eb; eb = et; mt = ma; ma = mb; mb = mt;
        end
        bus.i_exp_a = ea; bus.i_man_a = ma; bus.i_exp_b = eb; bus.i_man_b = mb;
    endtask

    task automatic check_idle(input string name);
        check({name, "_o_valid"}, bus.o_valid, 1'b0);
        check({name, "_o_ready"}, bus.o_ready, 1'b1);
        check({name, "_o_swap"}, bus.o_swap, 1'b0);
        check({name, "_o_sticky"}, bus.o_sticky, 1'b0);
        check({name, "_o_exp_big"}, bus.o_exp_big, '0);
        check({name, "_o_man_big"}, bus.o_man_big, '0);
        check({name, "_o_man_small"}, bus.o_man_small, '0);
    endtask

    // One pair into an empty pipe with i_ready high: result must show exactly two cycles later.
    task automatic directed(input string name, input logic [SE-1:0] ea, input logic [SM-1:0] ma,
                            input logic [SE-1:0] eb, input logic [SM-1:0] mb, input res_t req);
        @(posedge clk); #1;
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_exp_a = ea; bus.i_man_a = ma; bus.i_exp_b = eb; bus.i_man_b = mb;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        check({name, "_latency_early"}, bus.o_valid, 1'b0);
        @(negedge clk);
        check({name, "_latency"}, bus.o_valid, 1'b1);
        check_res(name, get_out(), req);
    endtask

    task automatic drain(input string name);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_in_eq_out"}, 64'(popped), 64'(pushed));
    endtask

    initial begin : main
        int pat[4] = '{1, 0, 0, 1};
        int sent;
        bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        bus.i_exp_a = '0; bus.i_exp_b = '0; bus.i_man_a = '0; bus.i_man_b = '0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Literal cases; d=1 puts the mantissa LSB into the guard position.
        directed("a_bigger_d2", 8'h82, 24'hC00000, 8'h80, 24'h800000,
                 mk(1'b0, 8'h82, 24'hC00000, 26'h0800000, 1'b0));
        directed("b_bigger_d1", 8'h80, 24'h800001, 8'h81, 24'hFFFFFF,
                 mk(1'b1, 8'h81, 24'hFFFFFF, 26'h1000002, 1'b0));
        directed("d31_flush", 8'h9F, 24'h800000, 8'h80, 24'h800001,
                 mk(1'b0, 8'h9F, 24'h800000, 26'h0, STICKY_ON));
        directed("equal_ops", 8'h85, 24'hA00000, 8'h85, 24'hA00000,
                 mk(1'b0, 8'h85, 24'hA00000, 26'h2800000, 1'b0));
        directed("d3_sticky", 8'h83, 24'h800000, 8'h80, 24'h800007,
                 mk(1'b0, 8'h83, 24'h800000, 26'h0400003, STICKY_ON));
        directed("d25_edge", 8'h99, 24'h800000, 8'h80, 24'h800000,
                 mk(1'b0, 8'h99, 24'h800000, 26'h0000001, 1'b0));
        directed("d26_edge", 8'h9A, 24'h800000, 8'h80, 24'h800000,
                 mk(1'b0, 8'h9A, 24'h800000, 26'h0, STICKY_ON));
        drain("directed");

        // Eight pairs with i_ready cycling 1,0,0,1 and random valid gaps.
        sent = 0;
        for (int cyc = 0; cyc < 300 && sent < 8; cyc++) begin
            @(posedge clk); #1;
            bus.i_ready = 1'(pat[cyc % 4]);
            bus.i_valid = ($urandom_range(0, 2) != 0);
            rand_ops();
            @(negedge clk);
            if (bus.i_valid && bus.o_ready) sent++;
        end
        @(posedge clk); #1;
        check("stream_sent", 64'(sent), 64'd8);
        drain("stream");

        // Long random valid/ready run.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            bus.i_ready = ($urandom_range(0, 9) < 7);
            bus.i_valid = ($urandom_range(0, 9) < 6);
            rand_ops();
        end
        @(posedge clk); #1;
        drain("random");

        // Fill both stages, then reset mid-flight: nothing may emerge afterwards.
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.i_valid = 1'b1;
            rand_ops();
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("full_o_valid", bus.o_valid, 1'b1);
        check("full_o_ready", bus.o_ready, 1'b0);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("midreset");
        bus.i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_reset_no_stale", bus.o_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #300000;
        mismatched++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
